// File: rtl/debug_trace_probe.sv
// Debug observation block: shows one of NCH channels live, or records it into a
// triggered circular trace buffer and plays it back on four 7-segment displays.
module debug_trace_probe #(
    parameter int NCH   = 6,
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int POST  = DEPTH / 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK1_50,
    input  logic             RST_N,
    input  logic [NCH*W-1:0] CH_DATA,
    input  logic [CW-1:0]    SEL,
    input  logic             STB,
    input  logic             ARM,
    input  logic             TRIG,
    input  logic             MODE,
    input  logic [AW-1:0]    RD_IDX,
    output logic [W-1:0]     DISP,
    output logic [7:0]       HEX0,
    output logic [7:0]       HEX1,
    output logic [7:0]       HEX2,
    output logic [7:0]       HEX3,
    output logic             ARMED,
    output logic             TRIGGERED,
    output logic             DONE,
    output logic [AW:0]      COUNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wptr;
    logic [AW:0]     count;
    logic [AW-1:0]   remaining;
    logic [W-1:0]    mem [DEPTH];
    logic [W-1:0]    live_val;
    logic [W-1:0]    play_val;
    logic [AW-1:0]   rd_addr;
    logic            buf_full;
    logic            wr_en;
    logic            trig_hit;
    logic [W-1:0]    disp_p1;
    logic [15:0]     disp16;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
        if (c == (AW+1)'(DEPTH))
            return c;
        return c + 1'b1;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Channel mux; out-of-range selects read as zero.
    always_comb begin
        live_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SEL == CW'(i))
                live_val = CH_DATA[i*W +: W];
        end
    end

    // ARM wins over a same-cycle strobe, so the strobe is dropped.
    assign wr_en    = !ARM && STB && (state == S_ARMED || state == S_POST);
    assign trig_hit = !ARM && STB && TRIG && (state == S_ARMED);

    always_ff @(posedge CLK1_50 or negedge RST_N) begin
        if (!RST_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ARM) begin
            state_nxt = S_ARMED;
        end else begin
            case (state)
                S_ARMED: if (STB && TRIG) state_nxt = (POST == 0) ? S_DONE : S_POST;
                S_POST:  if (STB && remaining == AW'(1)) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ARMED     = (state == S_ARMED);
        TRIGGERED = (state == S_POST);
        DONE      = (state == S_DONE);
    end

    always_ff @(posedge CLK1_50 or negedge RST_N) begin
        if (!RST_N) begin
            wptr      <= '0;
            count     <= '0;
            remaining <= '0;
        end else begin
            if (ARM) begin
                wptr  <= '0;
                count <= '0;
            end else if (wr_en) begin
                wptr  <= wptr + 1'b1;
                count <= sat_inc(count);
            end
            if (trig_hit)
                remaining <= AW'(POST);
            else if (wr_en && state == S_POST)
                remaining <= remaining - 1'b1;
        end
    end

    // Trace memory carries no reset; validity is tracked by count alone.
    always_ff @(posedge CLK1_50) begin
        if (wr_en)
            mem[wptr] <= live_val;
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign buf_full = (count == (AW+1)'(DEPTH));
    assign rd_addr  = buf_full ? (wptr + RD_IDX) : RD_IDX;
    assign play_val = ({1'b0, RD_IDX} < count) ? mem[rd_addr] : '0;

    // Stage p1: registered display value.
    always_ff @(posedge CLK1_50 or negedge RST_N) begin
        if (!RST_N)
            disp_p1 <= '0;
        else
            disp_p1 <= MODE ? play_val : live_val;
    end

    generate
        if (W >= 16) begin : g_wide
            assign disp16 = disp_p1[15:0];
        end else begin : g_narrow
            assign disp16 = {{(16-W){1'b0}}, disp_p1};
        end
    endgenerate

    assign DISP  = disp_p1;
    assign COUNT = count;
    assign HEX0  = seg7(disp16[3:0]);
    assign HEX1  = seg7(disp16[7:4]);
    assign HEX2  = seg7(disp16[11:8]);
    assign HEX3  = seg7(disp16[15:12]);

endmodule

// File: tb/tb_debug_trace_probe.sv
// Bench for debug_trace_probe: two instances (POST=4 and POST=0) share stimulus;
// a queue-based reference model feeds a scoreboard checked by a separate monitor.
module tb_debug_trace_probe;

    localparam int NCH   = 6;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH*W-1:0] ch_data;
    logic [2:0]      sel;
    logic            stb, arm, trig, mode;
    logic [2:0]      rd_idx;

    logic [15:0]     disp   [2];
    logic [7:0]      hx     [2][4];
    logic            armed_f[2];
    logic            trg_f  [2];
    logic            done_f [2];
    logic [3:0]      cnt    [2];

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;

    typedef struct {
        int          cyc;
        logic [15:0] d0, d1;
        logic [2:0]  f0, f1;
        logic [3:0]  c0, c1;
    } exp_t;
    exp_t sb[$];

    logic [15:0] bq0[$];
    logic [15:0] bq1[$];
    int mst[2];
    int rem[2];
    int post_of[2] = '{4, 0};
    logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    debug_trace_probe #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .POST(4)) dut0 (
        .CLK1_50(clk), .RST_N(rst_n), .CH_DATA(ch_data), .SEL(sel), .STB(stb),
        .ARM(arm), .TRIG(trig), .MODE(mode), .RD_IDX(rd_idx), .DISP(disp[0]),
        .HEX0(hx[0][0]), .HEX1(hx[0][1]), .HEX2(hx[0][2]), .HEX3(hx[0][3]),
        .ARMED(armed_f[0]), .TRIGGERED(trg_f[0]), .DONE(done_f[0]), .COUNT(cnt[0])
    );

    debug_trace_probe #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .POST(0)) dut1 (
        .CLK1_50(clk), .RST_N(rst_n), .CH_DATA(ch_data), .SEL(sel), .STB(stb),
        .ARM(arm), .TRIG(trig), .MODE(mode), .RD_IDX(rd_idx), .DISP(disp[1]),
        .HEX0(hx[1][0]), .HEX1(hx[1][1]), .HEX2(hx[1][2]), .HEX3(hx[1][3]),
        .ARMED(armed_f[1]), .TRIGGERED(trg_f[1]), .DONE(done_f[1]), .COUNT(cnt[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int j);
        return (j == 0) ? bq0.size() : bq1.size();
    endfunction

    function automatic logic [15:0] qget(input int j, input int k);
        return (j == 0) ? bq0[k] : bq1[k];
    endfunction

    task automatic qclear(input int j);
        if (j == 0) bq0.delete(); else bq1.delete();
    endtask

    // Keep only the newest DEPTH samples, oldest at the front.
    task automatic qpush(input int j, input logic [15:0] v);
        if (j == 0) begin
            bq0.push_back(v);
            if (bq0.size() > DEPTH) void'(bq0.pop_front());
        end else begin
            bq1.push_back(v);
            if (bq1.size() > DEPTH) void'(bq1.pop_front());
        end
    endtask

    task automatic model_one(input int j, input logic [15:0] live,
                             output logic [15:0] d, output logic [2:0] f, output logic [3:0] c);
        if (!rst_n) begin
            mst[j] = 0;
            rem[j] = 0;
            qclear(j);
            d = 16'h0;
        end else begin
            if (mode)
                d = (int'(rd_idx) < qsize(j)) ? qget(j, int'(rd_idx)) : 16'h0;
            else
                d = live;
            if (arm) begin
                qclear(j);
                mst[j] = 1;
            end else if (stb && (mst[j] == 1 || mst[j] == 2)) begin
                qpush(j, live);
                if (mst[j] == 1) begin
                    if (trig) begin
                        if (post_of[j] == 0) mst[j] = 3;
                        else begin mst[j] = 2; rem[j] = post_of[j]; end
                    end
                end else begin
                    rem[j]--;
                    if (rem[j] == 0) mst[j] = 3;
                end
            end
        end
        f = {mst[j] == 3, mst[j] == 2, mst[j] == 1};
        c = 4'(qsize(j));
    endtask

    task automatic tick();
        exp_t e;
        logic [15:0] live;
        int s;
        s = int'(sel);
        live = (s < NCH) ? ch_data[s*W +: W] : 16'h0;
        e.cyc = cycle_cnt + 1;
        model_one(0, live, e.d0, e.f0, e.c0);
        model_one(1, live, e.d1, e.f1, e.c1);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_inst(input int j, input logic [15:0] d, input logic [2:0] f, input logic [3:0] c);
        logic [31:0] hx_exp;
        hx_exp = {seg_tab[d[15:12]], seg_tab[d[11:8]], seg_tab[d[7:4]], seg_tab[d[3:0]]};
        check($sformatf("dut%0d_disp", j), 32'(disp[j]), 32'(d));
        check($sformatf("dut%0d_hex", j), {hx[j][3], hx[j][2], hx[j][1], hx[j][0]}, hx_exp);
        check($sformatf("dut%0d_flags", j), 32'({done_f[j], trg_f[j], armed_f[j]}), 32'(f));
        check($sformatf("dut%0d_count", j), 32'(cnt[j]), 32'(c));
    endtask

    // Monitor: compares every expectation whose edge has already happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
                e = sb.pop_front();
                cmp_inst(0, e.d0, e.f0, e.c0);
                cmp_inst(1, e.d1, e.f1, e.c1);
            end
        end
    end

    task automatic set_ch(input int i, input logic [15:0] v);
        ch_data[i*W +: W] = v;
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            check($sformatf("%s_dut%0d_flags", tag, j), 32'({done_f[j], trg_f[j], armed_f[j]}), 32'h0);
            check($sformatf("%s_dut%0d_count", tag, j), 32'(cnt[j]), 32'h0);
            check($sformatf("%s_dut%0d_disp", tag, j), 32'(disp[j]), 32'h0);
            check($sformatf("%s_dut%0d_hex", tag, j), {hx[j][3], hx[j][2], hx[j][1], hx[j][0]}, 32'hC0C0C0C0);
        end
    endtask

    initial begin
        rst_n = 1'b0; ch_data = '0; sel = 3'd0; stb = 1'b0; arm = 1'b0;
        trig = 1'b0; mode = 1'b0; rd_idx = 3'd0;
        repeat (3) tick();
        check("reset_hex0", {hx[0][3], hx[0][2], hx[0][1], hx[0][0]}, 32'hC0C0C0C0);
        check("reset_count0", 32'(cnt[0]), 32'h0);
        rst_n = 1'b1;
        tick();

        // Live view.
        set_ch(3, 16'h1A2F); sel = 3'd3; mode = 1'b0;
        tick();
        check("live_disp", 32'(disp[0]), 32'h1A2F);
        check("live_hex", {hx[0][3], hx[0][2], hx[0][1], hx[0][0]}, 32'hF988A48E);
        sel = 3'd7;
        tick();
        check("live_sel_oor", 32'(disp[0]), 32'h0);

        // Trigger on the 6th strobe, buffer wraps, capture stops after the 10th.
        sel = 3'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            set_ch(0, 16'(k)); stb = 1'b1; trig = (k == 6);
            tick();
            stb = 1'b0; trig = 1'b0;
            tick();
        end
        check("wrap_done", 32'(done_f[0]), 32'h1);
        check("wrap_count", 32'(cnt[0]), 32'h8);
        check("post0_count", 32'(cnt[1]), 32'h6);
        mode = 1'b1; rd_idx = 3'd0; tick();
        check("wrap_rd0", 32'(disp[0]), 32'h3);
        rd_idx = 3'd7; tick();
        check("wrap_rd7", 32'(disp[0]), 32'hA);
        mode = 1'b0;

        // ARM/STB collision, then immediate trigger on the POST=0 build.
        arm = 1'b1; stb = 1'b1; tick(); arm = 1'b0; stb = 1'b0;
        check("collide_count", 32'(cnt[0]), 32'h0);
        check("collide_armed", 32'(armed_f[0]), 32'h1);
        set_ch(0, 16'hBEEF); stb = 1'b1; trig = 1'b1; tick(); stb = 1'b0; trig = 1'b0;
        check("imm_done", 32'(done_f[1]), 32'h1);
        check("imm_count", 32'(cnt[1]), 32'h1);
        mode = 1'b1; rd_idx = 3'd0; tick();
        check("imm_rd0", 32'(disp[1]), 32'hBEEF);
        rd_idx = 3'd1; tick();
        check("imm_rd1", 32'(disp[1]), 32'h0);
        mode = 1'b0;

        // Reset in the middle of post-trigger capture.
        arm = 1'b1; tick(); arm = 1'b0;
        set_ch(0, 16'h0055); stb = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick(); stb = 1'b0;
        check("midpost_trig", 32'(trg_f[0]), 32'h1);
        async_reset_check("midpost_rst");
        stb = 1'b1; tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); stb = 1'b0; tick();
        check("after_rst_count", 32'(cnt[0]), 32'h0);
        check("after_rst_idle", 32'({done_f[0], trg_f[0], armed_f[0]}), 32'h0);

        // Re-arm from DONE.
        arm = 1'b1; tick(); arm = 1'b0;
        set_ch(0, 16'h1111); stb = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
        repeat (4) tick();
        stb = 1'b0;
        check("rearm_pre_done", 32'(done_f[0]), 32'h1);
        arm = 1'b1; tick(); arm = 1'b0;
        check("rearm_armed", 32'(armed_f[0]), 32'h1);
        check("rearm_count", 32'(cnt[0]), 32'h0);
        mode = 1'b1; rd_idx = 3'd0; tick();
        check("rearm_rd0_empty", 32'(disp[0]), 32'h0);
        set_ch(0, 16'h7E57); stb = 1'b1; tick(); stb = 1'b0; tick();
        check("rearm_rd0_new", 32'(disp[0]), 32'h7E57);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) set_ch(i, 16'($urandom));
            arm    = ($urandom_range(0, 19) == 0);
            stb    = $urandom_range(0, 1) == 1;
            trig   = ($urandom_range(0, 5) == 0);
            mode   = $urandom_range(0, 1) == 1;
            sel    = 3'($urandom_range(0, 7));
            rd_idx = 3'($urandom_range(0, 7));
            if (n == 200) async_reset_check("rand_rst");
            if (n == 203) rst_n = 1'b1;
            tick();
        end
        arm = 1'b0; stb = 1'b0; trig = 1'b0;
        tick(); tick();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_trace_probe.md
# debug_trace_probe

Parametrised debug observation block between the CPU's debug outputs (PC, state, opcode, ROM word, SP, address, …) and the board's HEX displays. Selects one of NCH channels and shows it live or records it into a triggered circular trace buffer for playback. Recording is strobed once per CPU step. Supersedes fixed per-signal debug wiring: channel count, width, trace depth and post-trigger length are all parameters.

## Interface
- NCH, 6: number of debug channels.
- W, 16: channel width in bits.
- DEPTH, 16: trace entries; power of two, ≥2.
- POST, DEPTH/2: samples recorded after the trigger sample, 0..DEPTH-1.
- AW, $clog2(DEPTH): derived; CW = $clog2(NCH), derived.

- CLK1_50  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CH_DATA  in  NCH*W  channel i at [i*W +: W].
- SEL  in  CW  channel select; used for both live view and capture.
- STB  in  1  capture strobe, one cycle per CPU step.
- ARM  in  1  single-cycle pulse: clear buffer and start capture.
- TRIG  in  1  trigger condition; qualified by STB.
- MODE  in  1  0 = live view, 1 = playback.
- RD_IDX  in  AW  playback index; 0 = oldest entry.
- DISP  out  W  displayed value, registered.
- HEX0..HEX3  out  8 each  active-low 7-segment decode of DISP[3:0]..DISP[15:12]; bit0 = a … bit6 = g, bit7 = dp (always 1). Bits above 15 are not shown. If W < 16, missing nibbles are 0.
- ARMED, TRIGGERED, DONE  out  1 each  one-hot state flags; all 0 in IDLE.
- COUNT  out  AW+1  valid entries, saturating at DEPTH.

## Operation
- State machine: IDLE → ARMED → POST → DONE.
- Reset enters IDLE with wptr = 0 and COUNT = 0. Memory contents are don't-care.
- ARM=1 in any state: wptr ← 0, COUNT ← 0, next state ARMED.
  - ARM has priority; an STB in the same cycle is dropped.
- Write rule, ARMED or POST with STB=1:
  - mem[wptr] ← CH_DATA[SEL].
  - wptr ← wptr+1 mod DEPTH (wraps).
  - COUNT ← min(COUNT+1, DEPTH).
- ARMED, STB=1, TRIG=1:
  - The trigger sample is written.
  - If POST = 0, go to DONE; otherwise go to POST with remaining ← POST.
- TRIG without STB is ignored.
- POST, STB=1: write; remaining−1; on reaching 0, go to DONE after this write.
  - TRIG is ignored in POST.
- DONE and IDLE: no writes. The state holds until ARM or reset.
- SEL ≥ NCH: captured/live value is 0.
- Playback address:
  - COUNT < DEPTH: RD_IDX.
  - COUNT = DEPTH: (wptr + RD_IDX) mod DEPTH.
  - RD_IDX ≥ COUNT gives DISP = 0.
- Playback is allowed in any state, including while capturing.
- Segment codes (0–F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

## Timing
- Reset values: DISP = 0, HEX0..3 = 8'hC0, ARMED = TRIGGERED = DONE = 0, COUNT = 0.
- DISP updates one cycle after SEL/CH_DATA/MODE/RD_IDX change. HEX is a combinational decode of the registered DISP, so it has the same latency.
- ARM at edge n: ARMED = 1 and COUNT = 0 visible after edge n. The first write can occur at edge n+1.
- STB write at edge n: COUNT and the state flags reflect it after edge n. Playback of that entry is valid on DISP after edge n+1.
- Reset asserted mid-capture: immediate return to IDLE with all outputs at reset values. Recording does not resume until ARM.

## Test plan
- Reset: hold RST_N=0, then release with no stimulus → DISP=0, all HEX=C0, flags 0, COUNT=0.
- Live view: CH_DATA ch3 = 16'h1A2F, SEL=3, MODE=0 → one cycle later DISP=1A2F, HEX3..0 = F9,88,A4,8E. Then SEL=7 (≥NCH) → DISP=0.
- Trigger and wrap (DEPTH=8, POST=4):
  - Stimulus: ARM, then 12 STBs with ch0 = 1..12, TRIG with the 6th.
  - DONE after the 10th STB; COUNT=8; samples 11 and 12 are not stored.
  - Playback: RD_IDX 0 → 3, RD_IDX 7 → 10.
- Collision and immediate trigger:
  - ARM and STB in the same cycle → COUNT stays 0.
  - POST=0 build, TRIG with the first STB → DONE, COUNT=1, RD_IDX 0 = that sample, RD_IDX 1 → 0.
- Reset mid-POST: drop RST_N after 2 post samples → IDLE with all flags 0 at once. Subsequent STBs are not recorded.
- Re-arm from DONE: ARM → ARMED, COUNT=0. Playback RD_IDX 0 gives DISP=0 until a new STB arrives.
